// File: rtl/free_list_pkg.sv
// free_list_pkg: shared sizes, pointer type and rename/commit handshake structs
// for the two-wide physical-register free list.
`default_nettype none

package free_list_pkg;

  localparam int PRF_NUM       = 64;
  localparam int PRF_NUM_WIDTH = 6;

  // Extra MSB is the wrap bit distinguishing full from empty.
  typedef logic [PRF_NUM_WIDTH:0] fl_ptr_t;

  typedef struct packed {
    logic req_0;
    logic req_1;
  } free_list_alloc;

  typedef struct packed {
    logic                     valid;
    logic                     wr;
    logic [PRF_NUM_WIDTH-1:0] stale_prf;
  } free_list_release;

  function automatic logic [1:0] pop2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/free_list_ram.sv
// free_list_ram: PRF_NUM x PRF_NUM_WIDTH free-list storage, 2 async reads, 2 sync writes.
// Optional FREE_LIST_CHECK_EN exposes the whole array for duplicate-release checking.
`default_nettype none

module free_list_ram
  import free_list_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PRF_NUM_WIDTH-1:0] rd_addr_0_i,
  output logic [PRF_NUM_WIDTH-1:0] rd_data_0_o,
  input  logic [PRF_NUM_WIDTH-1:0] rd_addr_1_i,
  output logic [PRF_NUM_WIDTH-1:0] rd_data_1_o,
  input  logic                     wr_en_0_i,
  input  logic [PRF_NUM_WIDTH-1:0] wr_addr_0_i,
  input  logic [PRF_NUM_WIDTH-1:0] wr_data_0_i,
  input  logic                     wr_en_1_i,
  input  logic [PRF_NUM_WIDTH-1:0] wr_addr_1_i,
  input  logic [PRF_NUM_WIDTH-1:0] wr_data_1_i
`ifdef FREE_LIST_CHECK_EN
  ,
  output logic [PRF_NUM-1:0][PRF_NUM_WIDTH-1:0] mem_o
`endif
);

  logic [PRF_NUM_WIDTH-1:0] mem_q [PRF_NUM];

  // Entry i starts as PRF i+1; the last entry is never inside the initial free window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PRF_NUM; i++) begin
        mem_q[i] <= (i == PRF_NUM - 1) ? '0 : PRF_NUM_WIDTH'(i + 1);
      end
    end else begin
      if (wr_en_0_i) mem_q[wr_addr_0_i] <= wr_data_0_i;
      if (wr_en_1_i) mem_q[wr_addr_1_i] <= wr_data_1_i;
    end
  end

  assign rd_data_0_o = mem_q[rd_addr_0_i];
  assign rd_data_1_o = mem_q[rd_addr_1_i];

`ifdef FREE_LIST_CHECK_EN
  always_comb begin
    for (int i = 0; i < PRF_NUM; i++) mem_o[i] = mem_q[i];
  end
`endif

endmodule

`default_nettype wire

// File: rtl/free_list.sv
// free_list: two-wide rename free list with speculative head, committed head and
// commit-driven tail. Define FREE_LIST_CHECK_EN to add the sticky fl_error output.
`default_nettype none

module free_list
  import free_list_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     recover,
  input  logic                     alloc_req_0,
  input  logic                     alloc_req_1,
  output logic                     alloc_ready,
  output logic [PRF_NUM_WIDTH-1:0] prf_new_0,
  output logic [PRF_NUM_WIDTH-1:0] prf_new_1,
  input  logic                     commit_valid_0,
  input  logic                     commit_valid_1,
  input  logic                     commit_wr_0,
  input  logic                     commit_wr_1,
  input  logic [PRF_NUM_WIDTH-1:0] commit_stale_prf_0,
  input  logic [PRF_NUM_WIDTH-1:0] commit_stale_prf_1,
  output logic [PRF_NUM_WIDTH:0]   free_count
`ifdef FREE_LIST_CHECK_EN
  ,
  output logic                     fl_error
`endif
);

  free_list_alloc   alloc;
  free_list_release rel_0, rel_1;

  fl_ptr_t    head_q, head_d, cmt_head_q, cmt_head_d, tail_q, tail_d;
  logic       cmt_0, cmt_1, free_0, free_1, alloc_fire;
  logic [1:0] n_alloc, n_free, n_cmt;

  assign alloc = '{req_0: alloc_req_0, req_1: alloc_req_1};
  assign rel_0 = '{valid: commit_valid_0, wr: commit_wr_0, stale_prf: commit_stale_prf_0};
  assign rel_1 = '{valid: commit_valid_1, wr: commit_wr_1, stale_prf: commit_stale_prf_1};

  always_comb begin
    cmt_0      = rel_0.valid & rel_0.wr;
    cmt_1      = rel_1.valid & rel_1.wr;
    // PRF 0 is architecturally pinned, so it is never pushed back.
    free_0     = cmt_0 & (rel_0.stale_prf != '0);
    free_1     = cmt_1 & (rel_1.stale_prf != '0);
    n_alloc    = pop2(alloc.req_0, alloc.req_1);
    n_free     = pop2(free_0, free_1);
    n_cmt      = pop2(cmt_0, cmt_1);
    free_count = tail_q - head_q;
    alloc_ready = free_count >= fl_ptr_t'(2);
    alloc_fire = alloc_ready & ~recover;
    cmt_head_d = cmt_head_q + fl_ptr_t'(n_cmt);
    tail_d     = tail_q + fl_ptr_t'(n_free);
    head_d     = head_q;
    if (recover)         head_d = cmt_head_d;
    else if (alloc_fire) head_d = head_q + fl_ptr_t'(n_alloc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q     <= '0;
      cmt_head_q <= '0;
      tail_q     <= fl_ptr_t'(PRF_NUM - 1);
    end else begin
      head_q     <= head_d;
      cmt_head_q <= cmt_head_d;
      tail_q     <= tail_d;
    end
  end

`ifdef FREE_LIST_CHECK_EN
  logic [PRF_NUM-1:0][PRF_NUM_WIDTH-1:0] mem;
`endif

  // Inst 1 reads one entry past inst 0 only when inst 0 also consumes an entry.
  free_list_ram u_ram (
    .clk         (clk),
    .rst         (rst),
    .rd_addr_0_i (head_q[PRF_NUM_WIDTH-1:0]),
    .rd_data_0_o (prf_new_0),
    .rd_addr_1_i (head_q[PRF_NUM_WIDTH-1:0] + PRF_NUM_WIDTH'(alloc.req_0)),
    .rd_data_1_o (prf_new_1),
    .wr_en_0_i   (free_0),
    .wr_addr_0_i (tail_q[PRF_NUM_WIDTH-1:0]),
    .wr_data_0_i (rel_0.stale_prf),
    .wr_en_1_i   (free_1),
    .wr_addr_1_i (tail_q[PRF_NUM_WIDTH-1:0] + PRF_NUM_WIDTH'(free_0)),
    .wr_data_1_i (rel_1.stale_prf)
`ifdef FREE_LIST_CHECK_EN
    ,
    .mem_o       (mem)
`endif
  );

`ifdef FREE_LIST_CHECK_EN
  logic                       err_alloc, err_over, err_dup, fl_error_q;
  logic [PRF_NUM_WIDTH+1:0]   fc_after;
  logic [PRF_NUM_WIDTH-1:0]   off;

  always_comb begin
    err_alloc = ~recover & (fl_ptr_t'(n_alloc) > free_count);
    fc_after  = {1'b0, free_count} + (PRF_NUM_WIDTH+2)'(n_free);
    err_over  = fc_after > (PRF_NUM_WIDTH+2)'(PRF_NUM - 1);
    err_dup   = free_0 & free_1 & (rel_0.stale_prf == rel_1.stale_prf);
    off       = '0;
    // An entry is live when its distance from head falls inside the free window.
    for (int i = 0; i < PRF_NUM; i++) begin
      off = PRF_NUM_WIDTH'(i) - head_q[PRF_NUM_WIDTH-1:0];
      if ({1'b0, off} < free_count) begin
        if (free_0 && mem[i] == rel_0.stale_prf) err_dup = 1'b1;
        if (free_1 && mem[i] == rel_1.stale_prf) err_dup = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fl_error_q <= 1'b0;
    else if (err_alloc | err_over | err_dup) fl_error_q <= 1'b1;
  end

  assign fl_error = fl_error_q;
`endif

endmodule

`default_nettype wire
